// File: rtl/sram_like_slave_if.sv
// Request/response bundle between a pipeline-stage initiator and the SRAM-like slave.
// The two stall lines are bench-driven back-pressure and travel with the initiator side.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_stall;
  logic        data_stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata, addr_stall, data_stall,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, addr_stall, data_stall,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// Word-addressed memory responder with fixed minimum latency, in-order completion
// and a bounded queue of accepted-but-unanswered requests.
module sram_like_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input logic              clk,
  input logic              reset,
  sram_like_slave_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(OUTSTANDING);
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic          wr;
    logic [31:0]   data;
    logic [LW-1:0] cd;
  } entry_t;

  logic [31:0]            r_mem [DEPTH];
  entry_t                 r_q   [OUTSTANDING];
  logic [OUTSTANDING-1:0] r_valid;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_retire;
  logic          w_addr_ok;
  logic          w_data_ok;
  logic [31:0]   w_cap_data;
  logic          w_unused_ok;

  assign w_idx       = bus.addr[AW+1:2];
  assign w_unused_ok = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

  // Slot count is the registered value only; a same-cycle retire does not open a slot.
  assign w_addr_ok  = bus.req & ~bus.addr_stall & ~reset & (r_count < CW'(OUTSTANDING));
  assign w_data_ok  = r_valid[r_head] & (r_q[r_head].cd == '0) & ~bus.data_stall & ~reset;
  assign w_accept   = bus.req & w_addr_ok;
  assign w_retire   = w_data_ok;
  assign w_cap_data = bus.wr ? 32'h0 : r_mem[w_idx];

  assign bus.addr_ok = w_addr_ok;
  assign bus.data_ok = w_data_ok;
  assign bus.rdata   = w_data_ok ? r_q[r_head].data : 32'h0;

  // Storage array survives reset; byte-lane writes on accept.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_accept && bus.wr && bus.wstrb[b]) begin
        r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Response queue: countdowns age every cycle, tail pushes on accept, head pops on retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (r_valid[i] && (r_q[i].cd != '0)) begin
          r_q[i].cd <= r_q[i].cd - LW'(1);
        end
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_q[r_tail]     <= '{wr: bus.wr, data: w_cap_data, cd: LW'(LATENCY - 1)};
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave (DEPTH 1024, LATENCY 2, OUTSTANDING 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_sram_like_slave;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  sram_like_slave_if bus ();

  sram_like_slave #(
    .DEPTH      (1024),
    .LATENCY    (2),
    .OUTSTANDING(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  // One complete transaction with bounded waits on both handshakes.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    int n;
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    samp();
    n = 0;
    while (!bus.addr_ok && n < 20) begin tick(); samp(); n++; end
    if (!bus.addr_ok) check("xfer_aok_timeout", 32'(bus.addr_ok), 32'd1);
    tick();
    idle();
    samp();
    n = 0;
    while (!bus.data_ok && n < 20) begin tick(); samp(); n++; end
    if (!bus.data_ok) check("xfer_dok_timeout", 32'(bus.data_ok), 32'd1);
    rd = bus.rdata;
    tick();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, a, d, 4'hf, dummy);
  endtask

  initial begin
    logic [31:0] rd;
    int k;
    logic e_aok, e_dok;
    logic [31:0] e_rd;
    n_tests = 0;
    n_fail  = 0;
    idle();
    bus.size       = 2'd2;
    bus.addr_stall = 1'b0;
    bus.data_stall = 1'b0;
    reset = 1'b1;

    // Reset held three cycles with req low, then released.
    for (int c = 0; c < 3; c++) begin
      samp();
      check($sformatf("rst_aok%0d", c), 32'(bus.addr_ok), 32'd0);
      check($sformatf("rst_dok%0d", c), 32'(bus.data_ok), 32'd0);
      check($sformatf("rst_rd%0d", c), bus.rdata, 32'h0);
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      samp();
      check($sformatf("post_aok%0d", c), 32'(bus.addr_ok), 32'd0);
      check($sformatf("post_dok%0d", c), 32'(bus.data_ok), 32'd0);
      tick();
    end

    // Single read with upper address bits set; word 0x40.
    preload(32'h0000_0100, 32'hdeadbeef);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h1c00_0100; end
      else idle();
      samp();
      check($sformatf("sr_aok%0d", c), 32'(bus.addr_ok), (c == 0) ? 32'd1 : 32'd0);
      check($sformatf("sr_dok%0d", c), 32'(bus.data_ok), (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("sr_rd%0d", c), bus.rdata, (c == 2) ? 32'hdeadbeef : 32'h0);
      tick();
    end

    // Full queue with data back-pressure until cycle 6.
    for (int i = 0; i < 5; i++) preload(32'(i * 4), 32'hA0 + 32'(i));
    k = 0;
    for (int c = 0; c < 12; c++) begin
      bus.data_stall = (c < 6);
      if (k < 5) begin bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'(k * 4); end
      else idle();
      e_aok = (c <= 3) || (c == 7);
      e_dok = (c >= 6) && (c <= 10);
      e_rd  = e_dok ? (32'hA0 + 32'(c - 6)) : 32'h0;
      samp();
      check($sformatf("fq_aok%0d", c), 32'(bus.addr_ok), 32'(e_aok));
      check($sformatf("fq_dok%0d", c), 32'(bus.data_ok), 32'(e_dok));
      check($sformatf("fq_rd%0d", c), bus.rdata, e_rd);
      if (e_aok) k++;
      tick();
    end
    bus.data_stall = 1'b0;
    idle();

    // Partial byte write then read of the same word.
    preload(32'h0000_0040, 32'hffffffff);
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h40;
                        bus.wdata = 32'h12345678; bus.wstrb = 4'b0011; end
      if (c == 1) begin bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h40; end
      samp();
      check($sformatf("bw_aok%0d", c), 32'(bus.addr_ok), (c <= 1) ? 32'd1 : 32'd0);
      check($sformatf("bw_dok%0d", c), 32'(bus.data_ok), (c == 2 || c == 3) ? 32'd1 : 32'd0);
      check($sformatf("bw_rd%0d", c), bus.rdata, (c == 3) ? 32'hffff5678 : 32'h0);
      tick();
    end

    // Read captured before a following full write to the same word.
    preload(32'h0000_0040, 32'h11111111);
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0 || c == 2) begin bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h40; end
      if (c == 1) begin bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h40;
                        bus.wdata = 32'h22222222; bus.wstrb = 4'hf; end
      samp();
      check($sformatf("rw_dok%0d", c), 32'(bus.data_ok), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      check($sformatf("rw_rd%0d", c), bus.rdata,
            (c == 2) ? 32'h11111111 : (c == 4) ? 32'h22222222 : 32'h0);
      tick();
    end

    // Reset discards outstanding reads; address wraps modulo DEPTH.
    for (int c = 0; c < 8; c++) begin
      idle();
      bus.data_stall = (c <= 2);
      reset = (c == 2);
      if (c <= 1) begin bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'(c * 4); end
      samp();
      if (c <= 1) check($sformatf("mr_aok%0d", c), 32'(bus.addr_ok), 32'd1);
      check($sformatf("mr_dok%0d", c), 32'(bus.data_ok), 32'd0);
      tick();
    end
    reset = 1'b0;
    bus.data_stall = 1'b0;
    xfer(1'b1, 32'h0000_1000, 32'hcafef00d, 4'hf, rd);
    check("wrap_wr_rd", rd, 32'h0);
    xfer(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd);
    check("wrap_rd", rd, 32'hcafef00d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
